// File: rtl/chi_pkg.sv
// Shared CHI flit types and encodings for the HN-F / SN-F channel models.
// Field set is the subset these nodes exchange; unused CHI fields are omitted.
package chi_pkg;

    localparam int unsigned CHI_DATA_W = 256;
    localparam int unsigned CHI_ADDR_W = 48;

    localparam logic [5:0] REQ_READ_SHARED = 6'h01;
    localparam logic [5:0] REQ_READ_NO_SNP = 6'h04;
    localparam logic [3:0] DAT_COMP_DATA   = 4'h4;

    localparam logic [2:0] RESP_I   = 3'b000;
    localparam logic [2:0] RESP_SC  = 3'b001;
    localparam logic [2:0] RESP_UC  = 3'b010;
    localparam logic [2:0] SIZE_64B = 3'b110;

    typedef struct packed {
        logic [3:0]            qos;
        logic [6:0]            tgt_id;
        logic [6:0]            src_id;
        logic [7:0]            txn_id;
        logic [5:0]            opcode;
        logic [2:0]            size;
        logic [CHI_ADDR_W-1:0] addr;
        logic                  ns;
        logic                  allow_retry;
        logic                  exp_comp_ack;
    } reqflit_t;

    typedef struct packed {
        logic [3:0]            qos;
        logic [6:0]            tgt_id;
        logic [6:0]            src_id;
        logic [7:0]            txn_id;
        logic [6:0]            home_nid;
        logic [3:0]            opcode;
        logic [1:0]            resp_err;
        logic [2:0]            resp;
        logic [7:0]            dbid;
        logic [1:0]            ccid;
        logic [1:0]            data_id;
        logic [31:0]           be;
        logic [CHI_DATA_W-1:0] data;
    } datflit_t;

    typedef enum logic [1:0] {StIdle, StMemReq, StWaitRsp, StSend} snf_state_e;

endpackage

// File: rtl/chi_flit_fifo.sv
// In-order flit queue; extra pointer MSB separates full from empty.
// A pop frees the head slot in the same cycle, so push+pop is legal when full.
module chi_flit_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic [7:0]
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem[rd_ptr_q[AW-1:0]];
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/snf_rxreq.sv
// SN-F end of the REQ channel: grants REQ credits, queues ReadNoSnp, reads the
// line from backing memory and returns it as CompData beats on TXDAT.
module snf_rxreq
    import chi_pkg::*;
#(
    parameter int unsigned REQ_DEPTH    = 4,
    parameter logic [6:0]  SNF_ID       = 7'h10,
    parameter int unsigned DAT_LCRD_MAX = 15,
    parameter int unsigned BEATS        = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  reqflit_t                    RXREQFLIT,
    input  logic                        RXREQFLITV,
    input  logic                        RXREQFLITPEND,
    output logic                        RXREQLCRDV,
    output datflit_t                    TXDATFLIT,
    output logic                        TXDATFLITV,
    output logic                        TXDATFLITPEND,
    input  logic                        TXDATLCRDV,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [47:0]                 mem_req_addr,
    input  logic                        mem_rsp_valid,
    input  logic [BEATS*CHI_DATA_W-1:0] mem_rsp_data,
    output logic                        err_unsupported
);
    localparam int unsigned CW = $clog2(REQ_DEPTH) + 1;
    localparam int unsigned DW = $clog2(DAT_LCRD_MAX + 1);
    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    snf_state_e                  state_q, state_d;
    reqflit_t                    work_q, work_d, fifo_head;
    logic [BEATS*CHI_DATA_W-1:0] line_q, line_d;
    logic [BW-1:0]               beat_q, beat_d;
    logic [CW-1:0]               granted_q, granted_d, fifo_count, occ_d;
    logic [DW-1:0]               dat_crd_q, dat_crd_d;
    logic                        lcrdv_q, lcrdv_d, err_q;
    logic                        req_ok, req_accept, req_drop;
    logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                        unused_ok;

    // A flit without a granted credit is a protocol error and is discarded.
    assign req_ok     = RXREQFLITV && (granted_q != '0);
    assign req_accept = req_ok && (RXREQFLIT.opcode == REQ_READ_NO_SNP);
    assign req_drop   = req_ok && (RXREQFLIT.opcode != REQ_READ_NO_SNP);

    chi_flit_fifo #(
        .DEPTH (REQ_DEPTH),
        .T     (reqflit_t)
    ) u_req_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (RXREQFLIT),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        line_d        = line_q;
        beat_d        = beat_q;
        fifo_pop      = 1'b0;
        fifo_push     = req_accept;
        mem_req_valid = 1'b0;
        TXDATFLITV    = 1'b0;
        TXDATFLITPEND = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    work_d   = fifo_head;
                    fifo_pop = 1'b1;
                    state_d  = StMemReq;
                end else if (req_accept) begin
                    // Empty queue: take the arriving flit directly.
                    work_d    = RXREQFLIT;
                    fifo_push = 1'b0;
                    state_d   = StMemReq;
                end
            end
            StMemReq: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = StWaitRsp;
            end
            StWaitRsp: begin
                if (mem_rsp_valid) begin
                    line_d        = mem_rsp_data;
                    beat_d        = '0;
                    state_d       = StSend;
                    TXDATFLITPEND = 1'b1;
                end
            end
            StSend: begin
                TXDATFLITPEND = 1'b1;
                if (dat_crd_q != '0) begin
                    TXDATFLITV = 1'b1;
                    if (beat_q == BW'(BEATS - 1)) begin
                        state_d       = StIdle;
                        TXDATFLITPEND = 1'b0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        granted_d = granted_q + CW'(lcrdv_q) - CW'(req_ok);
        occ_d     = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        lcrdv_d   = (32'(granted_d) + 32'(occ_d)) < REQ_DEPTH;
        dat_crd_d = dat_crd_q;
        if (TXDATLCRDV && !TXDATFLITV) begin
            if (dat_crd_q != DW'(DAT_LCRD_MAX)) dat_crd_d = dat_crd_q + 1'b1;
        end else if (!TXDATLCRDV && TXDATFLITV) begin
            dat_crd_d = dat_crd_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            work_q    <= '0;
            line_q    <= '0;
            beat_q    <= '0;
            granted_q <= '0;
            dat_crd_q <= '0;
            lcrdv_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            line_q    <= line_d;
            beat_q    <= beat_d;
            granted_q <= granted_d;
            dat_crd_q <= dat_crd_d;
            lcrdv_q   <= lcrdv_d;
            err_q     <= req_drop;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (RXREQFLITV && granted_q == '0) $error("snf_rxreq: REQ flit with no credit");
            if (req_accept && RXREQFLIT.size != SIZE_64B)
                $warning("snf_rxreq: non-64B Size treated as 64B");
            if (TXDATLCRDV && !TXDATFLITV && dat_crd_q == DW'(DAT_LCRD_MAX))
                $error("snf_rxreq: DAT credit received at saturation");
        end
    end

    assign RXREQLCRDV      = lcrdv_q;
    assign err_unsupported = err_q;
    assign mem_req_addr    = mem_req_valid ? {work_q.addr[47:6], 6'b0} : '0;

    always_comb begin
        TXDATFLIT = '0;
        if (TXDATFLITV) begin
            TXDATFLIT.opcode   = DAT_COMP_DATA;
            TXDATFLIT.tgt_id   = work_q.src_id;
            TXDATFLIT.src_id   = SNF_ID;
            TXDATFLIT.txn_id   = work_q.txn_id;
            TXDATFLIT.home_nid = work_q.src_id;
            TXDATFLIT.resp     = RESP_UC;
            TXDATFLIT.data_id  = 2'({beat_q, 1'b0});
            TXDATFLIT.be       = '1;
            TXDATFLIT.data     = line_q[32'(beat_q)*CHI_DATA_W +: CHI_DATA_W];
        end
    end

    assign unused_ok = ^{RXREQFLITPEND, work_q, fifo_full};

endmodule

// File: doc/snf_rxreq.md
Name: snf_rxreq

Overview:
- Slave-node (SN-F) end of the HN-F→SN-F CHI REQ channel.
- Grants L-credits on RXREQ and buffers incoming ReadNoSnp flits in an in-order queue.
- Fetches each line from a backing-memory port and returns the line as CompData on TXDAT toward the requesting HN-F.
- Gives the HN-F transmitter a real credit/response partner in simulation.

Parameters:
- REQ_DEPTH, 4, RXREQ queue entries; equals the maximum L-credits outstanding to the HN-F (power of 2, ≥2).
- SNF_ID, 7'h10, node ID driven in TXDAT SrcID.
- DAT_LCRD_MAX, 15, saturation value of the TXDAT credit counter.
- BEATS, 2, data beats per 64-byte line (256-bit data field).

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-high reset
- RXREQFLIT  input  reqflit_t  request flit from HN-F
- RXREQFLITV  input  1  flit valid; consumes one granted credit
- RXREQFLITPEND  input  1  early hint; ignored functionally
- RXREQLCRDV  output  1  one-cycle pulse grants one REQ L-credit
- TXDATFLIT  output  datflit_t  CompData flit to HN-F
- TXDATFLITV  output  1  flit valid
- TXDATFLITPEND  output  1  asserted the cycle before TXDATFLITV
- TXDATLCRDV  input  1  DAT L-credit from HN-F
- mem_req_valid  output  1  line read request
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  48  line address, Addr[5:0] forced to 0
- mem_rsp_valid  input  1  line data valid; in order, one per request
- mem_rsp_data  input  512  full line, beat 0 in bits [255:0]
- err_unsupported  output  1  one-cycle pulse when a non-ReadNoSnp flit is dropped

Behaviour:
- Reset values: all outputs 0; queue empty; granted=0; dat_crd=0; FSM in IDLE.
- REQ credits: keep count granted (0..REQ_DEPTH).
  - Pulse RXREQLCRDV while granted + occupancy < REQ_DEPTH, at most one pulse per cycle.
  - granted increments on a pulse and decrements on RXREQFLITV; both in the same cycle leaves it unchanged.
  - After reset, REQ_DEPTH pulses go out on consecutive cycles starting at cycle 1.
- RXREQFLITV with granted==0 is a protocol error: $error, and the flit is dropped.
- Enqueue: RXREQFLITV with Opcode==ReadNoSnp (6'h04) pushes the flit the same cycle.
  - Any other opcode is dropped: err_unsupported pulses, and the slot's credit is re-granted by the rule above.
  - Size != 3'b110 is treated as 64 B, with an $warning.
- Queue: circular buffer with log2(REQ_DEPTH)+1-bit pointers; full/empty is decided by the MSB compare.
  - Simultaneous push and pop is allowed when full, because the pop frees the slot in the same cycle.
  - Overflow cannot occur given the credit rule.
- FSM:
  - IDLE → MEM_REQ when the queue is not empty; the head is latched into a working register and popped.
  - MEM_REQ holds mem_req_valid=1 with the head address; on mem_req_ready → WAIT_RSP.
  - WAIT_RSP: on mem_rsp_valid, capture the line → SEND with beat=0.
  - SEND: when dat_crd>0, drive TXDATFLITV for one cycle and increment beat.
    - After beat BEATS-1 → IDLE; this may go straight to MEM_REQ next cycle if the queue is not empty.
    - With dat_crd==0, hold SEND, and PEND stays 1 while waiting.
- TXDAT fields:
  - Opcode=CompData (4'h4), TgtID=req.SrcID, SrcID=SNF_ID, TxnID=req.TxnID.
  - HomeNID=req.SrcID, DBID=0, Resp=3'b010 (UC).
  - DataID=beat*2 (so 0, 2), BE all ones, Data=line[beat*256 +: 256]; all other fields 0.
- DAT credits: dat_crd += TXDATLCRDV, -= TXDATFLITV, saturating at DAT_LCRD_MAX.
  - Simultaneous receive and use leaves the count unchanged.
  - A credit arriving at saturation triggers $error.
- Latency, empty queue with credits available:
  - Flit arrives at T; MEM_REQ at T+1; ready at T+1 → WAIT_RSP at T+2.
  - Beat 0 goes out the cycle after the mem_rsp_valid cycle; beat 1 the cycle after that.
- Reset mid-operation: all state is discarded with no drain. The HN-F is also reset and reclaims no credits.

Decomposition:
- chi_pkg (shared): reqflit_t, datflit_t, REQ/DAT opcode constants (ReadNoSnp, CompData), Resp encodings, CHI_DATA_W=256.
- One sub-module, chi_flit_fifo: parameterised depth and type, push/pop/full/empty. It is reusable by the HN-F receive channels.
- Credit counters and the FSM stay in snf_rxreq.

Test Plan:
- Reset release, no traffic → RXREQLCRDV pulses exactly 4 times on cycles 1-4, then stays low; TXDATFLITV stays 0.
- One ReadNoSnp {TxnID=8'h3A, SrcID=7'h01, Addr=48'h1000}, 2 DAT credits, mem ready at once, mem_rsp 3 cycles later → mem_req_addr=48'h1000; two CompData beats with TxnID 3A, TgtID 01, DataID 0 then 2 on consecutive cycles; one new REQ credit is issued after the pop.
- Four back-to-back ReadNoSnp with TxnID 0..3, DAT credits supplied one per cycle → responses in order 0,1,2,3, eight beats total; granted never exceeds 4.
- ReadNoSnp with no DAT credit for 10 cycles, then one TXDATLCRDV → FSM holds in SEND with PEND=1; beat 0 goes out only after the credit; beat 1 waits for a second credit.
- Opcode 6'h01 (ReadShared) → dropped; err_unsupported pulses once; no memory request; credit count restored to 4.
- Reset asserted while in WAIT_RSP → next cycle all outputs are 0, the queue is empty, and the credit grant sequence restarts.
